// File: rtl/rv_pkg.sv
// Shared rv core defaults so the register file, decoder and hazard unit agree
// on data width, register count and register address width.
package rv_pkg;
  localparam int RV_XLEN = 64;
  localparam int RV_NREG = 32;
  localparam int RV_AW   = $clog2(RV_NREG);
endpackage

// File: rtl/rv_sb.sv
// Scoreboard: one busy bit per architectural register plus a registered
// population count of the busy vector.
module rv_sb
  import rv_pkg::*;
#(
  parameter int NREG = RV_NREG,
  parameter int NWR  = 1,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              flush_i,
  output logic [NREG-1:0]   busy_o,
  output logic [CW-1:0]     pend_cnt_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Priority: flush beats issue, issue beats writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p]) busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
      end
      if (iss_en_i && iss_addr_i != '0) busy_d[iss_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/rv_rf_sb.sv
// Multi-port integer register file with optional same-cycle write-to-read
// bypass and a pending-write scoreboard.
module rv_rf_sb
  import rv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int NREG   = RV_NREG,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic [CW-1:0]       pend_cnt_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy;

  // Ports applied in ascending order so the highest-index port wins a collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) mem_d[i] = mem_q[i];
    for (int p = 0; p < NWR; p++) begin
      if (wr_en_i[p] && wr_addr_i[p*AW +: AW] != '0)
        mem_d[wr_addr_i[p*AW +: AW]] = wr_data_i[p*XLEN +: XLEN];
    end
  end

  // Full reset of the array keeps x0 at zero without a read-side mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
    end
  end

  rv_sb #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy),
    .pend_cnt_o (pend_cnt_o)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            hit;

    assign addr = rd_addr_i[gi*AW +: AW];

    always_comb begin
      data = mem_q[addr];
      hit  = 1'b0;
      if (BYPASS != 0 && addr != '0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == addr) begin
            data = wr_data_i[p*XLEN +: XLEN];
            hit  = 1'b1;
          end
        end
      end
    end

    assign rd_data_o[gi*XLEN +: XLEN] = data;
    assign rd_busy_o[gi]              = busy[addr] & ~hit;
  end

endmodule

// File: tb/tb_rv_rf_sb.sv
// Scoreboard bench for rv_rf_sb (NWR=2, NRD=2, BYPASS=1): the driver pushes the
// expected response of every cycle, a monitor pops and compares mid-cycle.
module tb_rv_rf_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wr_en_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                iss_en_i;
  logic [AW-1:0]       iss_addr_i;
  logic                flush_i;
  logic [CW-1:0]       pend_cnt_o;

  rv_rf_sb #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .flush_i    (flush_i),
    .pend_cnt_o (pend_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [1:0]      b;
    int              cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_id = 0;

  // Architectural model: what each register holds and which are awaiting a result.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int id, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, id, act, req);
    end
  endtask

  // One stimulus cycle: drive, predict, push, advance the model, wait an edge.
  task automatic cyc(input int ra0, input int ra1, input logic [1:0] we,
                     input int wa0, input int wa1, input logic [XLEN-1:0] wd0,
                     input logic [XLEN-1:0] wd1, input logic ie, input int ia,
                     input logic fl);
    exp_t e;
    int   ra [2];
    int   wa [2];
    logic [XLEN-1:0] wd [2];
    ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;

    rd_addr_i  = {AW'(ra1), AW'(ra0)};
    wr_en_i    = we;
    wr_addr_i  = {AW'(wa1), AW'(wa0)};
    wr_data_i  = {wd1, wd0};
    iss_en_i   = ie;
    iss_addr_i = AW'(ia);
    flush_i    = fl;

    e.id  = cyc_id;
    e.cnt = model_pending();
    e.b   = '0;
    for (int k = 0; k < 2; k++) begin
      logic [XLEN-1:0] v;
      bit wr_now = 0;
      v = m_mem[ra[k]];
      if (ra[k] != 0) begin
        for (int p = 1; p >= 0; p--) begin
          if (!wr_now && we[p] && wa[p] == ra[k]) begin
            v = wd[p];
            wr_now = 1;
          end
        end
      end else begin
        v = '0;
      end
      if (k == 0) e.d0 = v; else e.d1 = v;
      e.b[k] = (ra[k] != 0) && m_busy[ra[k]] && !wr_now;
    end
    exp_q.push_back(e);

    if (rstn) begin
      for (int p = 0; p < 2; p++) if (we[p] && wa[p] != 0) m_mem[wa[p]] = wd[p];
      if (fl) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) if (we[p]) m_busy[wa[p]] = 1'b0;
        if (ie && ia != 0) m_busy[ia] = 1'b1;
      end
    end

    cyc_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_read(input int a0, input int a1);
    cyc(a0, a1, 2'b00, 0, 0, '0, '0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: every cycle is an output; compare whatever the driver predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data0", e.id, rd_data_o[XLEN-1:0], e.d0);
        chk("rd_data1", e.id, rd_data_o[2*XLEN-1:XLEN], e.d1);
        chk("rd_busy0", e.id, XLEN'(rd_busy_o[0]), XLEN'(e.b[0]));
        chk("rd_busy1", e.id, XLEN'(rd_busy_o[1]), XLEN'(e.b[1]));
        chk("pend_cnt", e.id, XLEN'(pend_cnt_o), XLEN'(e.cnt));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    rd_addr_i = '0; wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
    iss_en_i = 1'b0; iss_addr_i = '0; flush_i = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    idle_read(0, 5);
    rstn = 1'b1;

    // x0 write ignored
    cyc(0, 0, 2'b01, 0, 0, 64'hDEAD, '0, 1'b0, 0, 1'b0);
    idle_read(0, 1);
    // write then read, with same-cycle bypass
    cyc(5, 6, 2'b01, 5, 0, 64'h1234, '0, 1'b0, 0, 1'b0);
    idle_read(5, 6);
    // collision: port 1 wins
    cyc(7, 5, 2'b11, 7, 7, 64'h11, 64'h22, 1'b0, 0, 1'b0);
    idle_read(7, 5);
    // issue x3, then write x3 clears it (bypass hides busy on write cycle)
    cyc(3, 0, 2'b00, 0, 0, '0, '0, 1'b1, 3, 1'b0);
    idle_read(3, 4);
    cyc(3, 7, 2'b01, 3, 0, 64'h33, '0, 1'b0, 0, 1'b0);
    idle_read(3, 0);
    // issue + write same register: producer wins
    cyc(3, 0, 2'b00, 0, 0, '0, '0, 1'b1, 3, 1'b0);
    cyc(3, 0, 2'b10, 0, 3, '0, 64'h9, 1'b1, 3, 1'b0);
    idle_read(3, 0);
    // issue to x0 ignored
    cyc(0, 3, 2'b00, 0, 0, '0, '0, 1'b1, 0, 1'b0);
    // flush beats a same-cycle issue
    cyc(1, 2, 2'b00, 0, 0, '0, '0, 1'b1, 1, 1'b0);
    cyc(1, 2, 2'b00, 0, 0, '0, '0, 1'b1, 2, 1'b0);
    cyc(4, 1, 2'b00, 0, 0, '0, '0, 1'b1, 4, 1'b0);
    cyc(4, 6, 2'b00, 0, 0, '0, '0, 1'b1, 6, 1'b1);
    idle_read(6, 4);

    // randomized traffic over a small address window to force collisions
    for (int n = 0; n < 300; n++) begin
      int ra0, ra1, wa0, wa1, ia;
      logic [1:0] we;
      ra0 = $urandom_range(0, 7); ra1 = $urandom_range(0, 7);
      wa0 = $urandom_range(0, 7); wa1 = $urandom_range(0, 7);
      ia  = $urandom_range(0, 7);
      we  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra1 = wa1;
      cyc(ra0, ra1, we, wa0, wa1, {$urandom, $urandom}, {$urandom, $urandom},
          1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 19) == 0));
      if (n == 150) begin
        // asynchronous reset asserted mid-cycle
        rstn = 1'b0;
        model_clear();
        idle_read(3, 5);
        idle_read(7, 1);
        rstn = 1'b1;
        idle_read(2, 4);
      end
    end
    idle_read(0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
